// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: load/store/stack strobes, SP ownership, 32-bit split.
// Optional SP guard enabled by defining MEM_ACCESS_CTRL_SP_GUARD_EN (adds stack_fault).
module mem_access_ctrl #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_SIZE = 11,
   parameter logic [ADDR_SIZE-1:0] SP_INIT = {ADDR_SIZE{1'b1}}
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   input  logic [2:0]             op,
   input  logic [ADDR_SIZE-1:0]   ea,
   input  logic [2*WORD_SIZE-1:0] wdata,
   output logic                   busy,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [ADDR_SIZE-1:0]   mem_addr,
   output logic [WORD_SIZE-1:0]   mem_wd,
   input  logic [WORD_SIZE-1:0]   mem_rd,
   output logic [2*WORD_SIZE-1:0] rdata,
   output logic                   rdata_valid,
`ifdef MEM_ACCESS_CTRL_SP_GUARD_EN
   output logic                   stack_fault,
`endif
   output logic [ADDR_SIZE-1:0]   sp
);

   typedef enum logic {S_IDLE, S_SECOND} state_t;

   localparam logic [2:0] OP_LOAD   = 3'd1;
   localparam logic [2:0] OP_STORE  = 3'd2;
   localparam logic [2:0] OP_PUSH   = 3'd3;
   localparam logic [2:0] OP_POP    = 3'd4;
   localparam logic [2:0] OP_PUSH32 = 3'd5;
   localparam logic [2:0] OP_POP32  = 3'd6;

   localparam logic [ADDR_SIZE-1:0] ONE = ADDR_SIZE'(1);
   localparam logic [ADDR_SIZE-1:0] TWO = ADDR_SIZE'(2);

   state_t                 state_q, state_d;
   logic [ADDR_SIZE-1:0]   sp_q, sp_d;
   logic [2*WORD_SIZE-1:0] rdata_q, rdata_d;
   logic                   rvalid_q, rvalid_d;
   logic [WORD_SIZE-1:0]   lo_q, lo_d;
   logic                   pop32_q, pop32_d;
   logic                   fault;

   logic                   rd_en, wr_en;
   logic [ADDR_SIZE-1:0]   sp_p1, sp_p2, sp_m1, sp_m2;
   logic [2*WORD_SIZE-1:0] rd_ext;
   logic                   is32;

   assign sp_p1  = sp_q + ONE;
   assign sp_p2  = sp_q + TWO;
   assign sp_m1  = sp_q - ONE;
   assign sp_m2  = sp_q - TWO;
   assign rd_ext = {{WORD_SIZE{1'b0}}, mem_rd};
   assign is32   = (op == OP_PUSH32) || (op == OP_POP32);

   always_comb begin
      fault = 1'b0;
`ifdef MEM_ACCESS_CTRL_SP_GUARD_EN
      if (state_q == S_IDLE && req_valid) begin
         case (op)
            OP_PUSH:   fault = (sp_q == '0);
            OP_PUSH32: fault = (sp_q <= ONE);
            OP_POP:    fault = (sp_q == SP_INIT);
            OP_POP32:  fault = (sp_q >= SP_INIT - ONE);
            default:   fault = 1'b0;
         endcase
      end
`endif
   end

   assign busy = (state_q == S_IDLE) && req_valid && is32 && !fault;

   always_comb begin
      state_d  = state_q;
      sp_d     = sp_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      lo_d     = lo_q;
      pop32_d  = pop32_q;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      mem_addr = ea;
      mem_wd   = wdata[WORD_SIZE-1:0];
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && !fault) begin
               case (op)
                  OP_LOAD: begin
                     rd_en    = 1'b1;
                     rdata_d  = rd_ext;
                     rvalid_d = 1'b1;
                  end
                  OP_STORE: wr_en = 1'b1;
                  OP_PUSH: begin
                     wr_en    = 1'b1;
                     mem_addr = sp_q;
                     sp_d     = sp_m1;
                  end
                  OP_POP: begin
                     rd_en    = 1'b1;
                     mem_addr = sp_p1;
                     sp_d     = sp_p1;
                     rdata_d  = rd_ext;
                     rvalid_d = 1'b1;
                  end
                  OP_PUSH32: begin
                     wr_en    = 1'b1;
                     mem_addr = sp_q;
                     mem_wd   = wdata[2*WORD_SIZE-1:WORD_SIZE];
                     pop32_d  = 1'b0;
                     state_d  = S_SECOND;
                  end
                  OP_POP32: begin
                     rd_en    = 1'b1;
                     mem_addr = sp_p1;
                     lo_d     = mem_rd;
                     pop32_d  = 1'b1;
                     state_d  = S_SECOND;
                  end
                  default: ;
               endcase
            end
         end
         S_SECOND: begin
            // Inputs are held by upstream; only the latched direction matters.
            state_d = S_IDLE;
            if (pop32_q) begin
               rd_en    = 1'b1;
               mem_addr = sp_p2;
               rdata_d  = {mem_rd, lo_q};
               rvalid_d = 1'b1;
               sp_d     = sp_p2;
            end else begin
               wr_en    = 1'b1;
               mem_addr = sp_m1;
               sp_d     = sp_m2;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_read    = rd_en & ~rst;
   assign mem_write   = wr_en & ~rst;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign sp          = sp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sp_q     <= SP_INIT;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         lo_q     <= '0;
         pop32_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sp_q     <= sp_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         lo_q     <= lo_d;
         pop32_q  <= pop32_d;
      end
   end

`ifdef MEM_ACCESS_CTRL_SP_GUARD_EN
   logic fault_q, fault_d;

   assign fault_d     = fault;
   assign stack_fault = fault_q;

   always_ff @(posedge clk) begin
      if (rst) fault_q <= 1'b0;
      else     fault_q <= fault_d;
   end
`endif

endmodule
